sobel_window_buffer: RTL

//  Upstream feeder for the Sobel multiplier stage. It accepts a raster-order 8-bit grey pixel

---
 rtl/sobel_window_buffer_pkg.sv | 10 +
 rtl/sobel_line_ram.sv | 26 ++
 rtl/sobel_window_buffer.sv | 89 ++++++++
 3 files changed

// File: rtl/sobel_window_buffer_pkg.sv
// Shared constants for the Sobel window buffer and multiplier stage.
// Pixel and hold-word widths plus default image geometry.
package sobel_window_buffer_pkg;

    localparam int PIX_W    = 8;
    localparam int HOLD_W   = 3 * PIX_W;
    localparam int IMGW_DEF = 384;
    localparam int IMGH_DEF = 1024;

endpackage

// File: rtl/sobel_line_ram.sv
// One image row of pixel storage.
// Async read, sync write; a read at the write address returns old data.
module sobel_line_ram
    import sobel_window_buffer_pkg::*;
#(
    parameter int DEPTH = IMGW_DEF,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/sobel_window_buffer.sv
// 3x3 neighbourhood assembler for a raster pixel stream.
// Two line RAMs delay the stream by one and two rows.
module sobel_window_buffer
    import sobel_window_buffer_pkg::*;
#(
    parameter int IMGW = IMGW_DEF,
    parameter int IMGH = IMGH_DEF,
    parameter int COLW = 9,
    parameter int ROWW = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PIX_W-1:0]  pixelIn,
    input  logic              pixelValid,
    input  logic              sof,
    output logic [HOLD_W-1:0] sobelHoldOutA,
    output logic [HOLD_W-1:0] sobelHoldOutB,
    output logic [HOLD_W-1:0] sobelHoldOutC,
    output logic              windowValid,
    output logic              frameDone
);

    localparam logic [COLW-1:0] COL_LAST = COLW'(IMGW - 1);
    localparam logic [ROWW-1:0] ROW_LAST = ROWW'(IMGH - 1);

    logic [COLW-1:0]  col;
    logic [ROWW-1:0]  row;
    logic [COLW-1:0]  addr;
    logic [PIX_W-1:0] midPix;
    logic [PIX_W-1:0] topPix;
    logic             lastCol;
    logic             lastRow;

    // sof forces the pixel to column 0 regardless of the counter
    assign addr    = sof ? '0 : col;
    assign lastCol = (col == COL_LAST);
    assign lastRow = (row == ROW_LAST);

    sobel_line_ram #(.DEPTH(IMGW), .AW(COLW)) lb0 (
        .clk   (clk),
        .we    (pixelValid),
        .addr  (addr),
        .wdata (pixelIn),
        .rdata (midPix)
    );

    sobel_line_ram #(.DEPTH(IMGW), .AW(COLW)) lb1 (
        .clk   (clk),
        .we    (pixelValid),
        .addr  (addr),
        .wdata (midPix),
        .rdata (topPix)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col           <= '0;
            row           <= '0;
            sobelHoldOutA <= '0;
            sobelHoldOutB <= '0;
            sobelHoldOutC <= '0;
            windowValid   <= 1'b0;
            frameDone     <= 1'b0;
        end else if (pixelValid) begin
            sobelHoldOutA <= {sobelHoldOutA[15:0], topPix};
            sobelHoldOutB <= {sobelHoldOutB[15:0], midPix};
            sobelHoldOutC <= {sobelHoldOutC[15:0], pixelIn};
            if (sof) begin
                col         <= COLW'(1);
                row         <= '0;
                windowValid <= 1'b0;
                frameDone   <= 1'b0;
            end else begin
                windowValid <= (row >= ROWW'(2)) && (col >= COLW'(2));
                frameDone   <= lastCol && lastRow;
                if (lastCol) begin
                    col <= '0;
                    row <= lastRow ? '0 : row + ROWW'(1);
                end else begin
                    col <= col + COLW'(1);
                end
            end
        end else begin
            windowValid <= 1'b0;
            frameDone   <= 1'b0;
        end
    end

endmodule
